// File: rtl/spi_flash_ctrl.sv
// SPI NOR flash read controller: power-up wake (0xAB), then 32-bit little-endian word reads.
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned POWERUP_CYCLES = 1000,
    parameter int unsigned WAKE_CYCLES    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  strobe_i,
    output logic [31:0]           rdata_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  initialized_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_no,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int unsigned TxW     = 8 + ADDR_WIDTH;
    localparam int unsigned DivW    = $clog2(2 * CLK_DIV);
    localparam int unsigned MaxWait = (POWERUP_CYCLES > WAKE_CYCLES) ? POWERUP_CYCLES
                                                                     : WAKE_CYCLES;
    localparam int unsigned CntW    = $clog2(MaxWait + 1);

    localparam logic [DivW-1:0] DivHalf   = DivW'(CLK_DIV);
    localparam logic [DivW-1:0] DivLast   = DivW'(2 * CLK_DIV - 1);
    localparam logic [CntW-1:0] PwrupLast = CntW'(POWERUP_CYCLES - 1);
    localparam logic [CntW-1:0] WakeLast  = CntW'(WAKE_CYCLES - 1);
    localparam logic [6:0]      ByteLast  = 7'd7;
    localparam logic [6:0]      AddrLast  = 7'(ADDR_WIDTH - 1);
    localparam logic [6:0]      WordLast  = 7'd31;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] ReadCmd = 8'h0B;
`else
    localparam logic [7:0] ReadCmd = 8'h03;
`endif

    typedef enum logic [2:0] {
        StPwrup,
        StWakeCmd,
        StWakeGap,
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData
    } state_e;

    state_e          state_q, state_d;
    state_e          next_shift;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic [6:0]      bit_q, bit_d;
    logic [6:0]      last_bit;
    logic [TxW-1:0]  tx_q, tx_d;
    logic [31:0]     rx_q, rx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            init_q, init_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            sck_q, sck_d;
    logic            cs_q, cs_d;
    logic            mosi_q, mosi_d;
    logic            miso_q1, miso_q2;
    logic            shifting_d;
    logic            bit_end;
    logic            unused_addr;

    // Word alignment: the low address bits never reach the flash.
    assign unused_addr = ^addr_i[1:0];

    // Per-shift-state bit count and successor.
    always_comb begin
        last_bit   = ByteLast;
        next_shift = StIdle;
        case (state_q)
            StWakeCmd: next_shift = StWakeGap;
            StCmd:     next_shift = StAddr;
            StAddr: begin
                last_bit = AddrLast;
`ifdef SPI_FLASH_FAST_READ_EN
                next_shift = StDummy;
`else
                next_shift = StData;
`endif
            end
            StDummy:   next_shift = StData;
            StData: begin
                last_bit   = WordLast;
                next_shift = StIdle;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        init_d  = init_q;
        done_d  = 1'b0;
        bit_end = (div_q == DivLast);

        unique case (state_q)
            StPwrup: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PwrupLast) begin
                    state_d = StWakeCmd;
                    cnt_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = {8'hAB, {ADDR_WIDTH{1'b0}}};
                end
            end
            StWakeGap: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WakeLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                end
            end
            StIdle: begin
                // done_q blocks an accept in the completion cycle itself.
                if (strobe_i && init_q && !busy_q && !done_q) begin
                    state_d = StCmd;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = {ReadCmd, addr_i[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            StWakeCmd, StCmd, StAddr, StDummy, StData: begin
                div_d = div_q + 1'b1;
                if (state_q == StData && div_q == DivHalf) begin
                    rx_d = {rx_q[30:0], miso_q2};
                end
                if (bit_end) begin
                    div_d = '0;
                    bit_d = bit_q + 7'd1;
                    tx_d  = {tx_q[TxW-2:0], 1'b0};
                    if (bit_q == last_bit) begin
                        bit_d   = '0;
                        cnt_d   = '0;
                        state_d = next_shift;
                        if (state_q == StData) begin
                            done_d  = 1'b1;
                            rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                        end
                    end
                end
            end
            default: state_d = StPwrup;
        endcase

        // SPI pins are registered from the next state so they are glitch-free.
        shifting_d = state_d inside {StWakeCmd, StCmd, StAddr, StDummy, StData};
        cs_d       = ~shifting_d;
        sck_d      = shifting_d && (div_d >= DivHalf);
        mosi_d     = (state_d inside {StWakeCmd, StCmd, StAddr}) ? tx_d[TxW-1] : 1'b0;
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StPwrup;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            miso_q1 <= 1'b0;
            miso_q2 <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            init_q  <= init_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            miso_q1 <= spi_miso_i;
            miso_q2 <= miso_q1;
        end
    end

    assign rdata_o       = rdata_q;
    assign done_o        = done_q;
    assign busy_o        = busy_q;
    assign initialized_o = init_q;
    assign spi_sck_o     = sck_q;
    assign spi_cs_no     = cs_q;
    assign spi_mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl with a behavioural SPI NOR flash model.
// Honours SPI_FLASH_FAST_READ_EN for command, dummy bits and latency.
module tb_spi_flash_ctrl;

    localparam int unsigned ClkDiv = 2;
    localparam int unsigned Pwrup  = 20;
    localparam int unsigned Wake   = 8;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] RdCmd     = 8'h0B;
    localparam int         Lat       = 289;
    localparam int         FirstData = 40;
`else
    localparam logic [7:0] RdCmd     = 8'h03;
    localparam int         Lat       = 257;
    localparam int         FirstData = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] addr = '0;
    logic        strobe = 1'b0;
    logic [31:0] rdata;
    logic        done, busy, init_done, sck, cs_n, mosi;
    logic        miso = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata = '0;

    // Flash model state
    int          rise_cnt = 0;
    int          rises_last = 0;
    int          cs_low_cur = 0;
    int          cs_low_last = 0;
    int          done_cnt = 0;
    logic [63:0] mosi_sh = '0;
    logic [31:0] cap_cmdaddr = '0;
    logic [7:0]  cap_first = '0;
    logic [7:0]  cap_dummy = '0;
    logic        sck_prev = 1'b0;
    logic        cs_prev = 1'b1;

    spi_flash_ctrl #(
        .ADDR_WIDTH    (24),
        .CLK_DIV       (ClkDiv),
        .POWERUP_CYCLES(Pwrup),
        .WAKE_CYCLES   (Wake)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .addr_i       (addr),
        .strobe_i     (strobe),
        .rdata_o      (rdata),
        .done_o       (done),
        .busy_o       (busy),
        .initialized_o(init_done),
        .spi_sck_o    (sck),
        .spi_cs_no    (cs_n),
        .spi_mosi_o   (mosi),
        .spi_miso_i   (miso)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (a[23:2] == 22'h080000) begin
            case (a[1:0])
                2'd0:    return 8'h11;
                2'd1:    return 8'h22;
                2'd2:    return 8'h33;
                default: return 8'h44;
            endcase
        end
        return a[7:0] ^ 8'h5A;
    endfunction

    // Mode-0 flash: capture MOSI on SCK rise, drive MISO after SCK fall.
    always @(negedge clk) begin
        int          n;
        logic [7:0]  b;
        logic [23:0] a;
        if (cs_n) begin
            if (!cs_prev) begin
                cs_low_last = cs_low_cur;
                rises_last  = rise_cnt;
            end
            rise_cnt   = 0;
            cs_low_cur = 0;
            miso       = 1'b0;
        end else begin
            cs_low_cur = cs_low_cur + 1;
            if (sck && !sck_prev) begin
                mosi_sh  = {mosi_sh[62:0], mosi};
                rise_cnt = rise_cnt + 1;
                if (rise_cnt == 8)  cap_first   = mosi_sh[7:0];
                if (rise_cnt == 32) cap_cmdaddr = mosi_sh[31:0];
                if (rise_cnt == 40) cap_dummy   = mosi_sh[7:0];
            end else if (!sck && sck_prev && rise_cnt >= FirstData) begin
                n = rise_cnt - FirstData;
                if (n < 32) begin
                    a    = cap_cmdaddr[23:0] + 24'(n / 8);
                    b    = byte_at(a);
                    miso = b[7 - (n % 8)];
                end
            end
        end
        if (done) done_cnt = done_cnt + 1;
        sck_prev = sck;
        cs_prev  = cs_n;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < Pwrup + Wake + 200; k++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs got=%b want=1", cs_n); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck got=%b want=0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got=%b want=0", mosi); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init got=%b want=0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b want=1", busy); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        rst_n      = 1'b1;
        last_rdata = '0;
    endtask

    // Runs straight after test_reset releases reset.
    task automatic test_init();
        bit pw_bad = 1'b0;
        int low_n, init_n;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (cs_n !== 1'b1) pw_bad = 1'b1;
        end
        checks++; if (pw_bad) begin errors++; $display("FAIL pwrup_cs_high got=low want=high"); end
        @(negedge clk);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL wake_cs_fall got=%b want=0", cs_n); end
        low_n = 1;
        for (int k = 0; k < 100 && cs_n === 1'b0; k++) begin
            @(negedge clk);
            if (cs_n === 1'b0) low_n++;
        end
        #1;
        checks++; if (low_n != 32) begin errors++; $display("FAIL wake_cs_len got=%0d want=32", low_n); end
        checks++;
        if (cap_first !== 8'hAB) begin errors++; $display("FAIL wake_cmd got=%h want=ab", cap_first); end
        checks++; if (rises_last != 8) begin errors++; $display("FAIL wake_bits got=%0d want=8", rises_last); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b want=1", busy); end
        init_n = 0;
        for (int k = 0; k < 100 && !init_done; k++) begin
            init_n++;
            @(negedge clk);
        end
        checks++; if (init_n != 8) begin errors++; $display("FAIL init_delay got=%0d want=8", init_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy got=%b want=0", busy); end
    endtask

    task automatic test_read();
        logic [23:0] va [3] = '{24'h200002, 24'h000107, 24'hFFFFFF};
        logic [23:0] vl [3] = '{24'h200000, 24'h000104, 24'hFFFFFC};
        logic [31:0] vd [3] = '{32'h44332211, 32'h5D5C5F5E, 32'hA5A4A7A6};
        for (int v = 0; v < 3; v++) begin
            int done_k = -1;
            int rise_k = -1;
            @(negedge clk);
            strobe = 1'b1;
            addr   = va[v];
            @(posedge clk);
            #1 strobe = 1'b0;
            for (int k = 1; k < Lat + 20; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    checks++;
                    if (cs_n !== 1'b0 || busy !== 1'b1) begin
                        errors++; $display("FAIL rd%0d_start cs=%b busy=%b want cs=0 busy=1", v, cs_n, busy);
                    end
                end
                if (sck === 1'b1 && rise_k < 0) rise_k = k;
                if (k == Lat - 1) begin
                    checks++;
                    if (rdata !== last_rdata) begin
                        errors++; $display("FAIL rd%0d_early got=%h want=%h", v, rdata, last_rdata);
                    end
                end
                if (done === 1'b1) begin
                    done_k = k;
                    break;
                end
            end
            checks++;
            if (rise_k != 1 + ClkDiv) begin
                errors++; $display("FAIL rd%0d_sck_rise got=%0d want=%0d", v, rise_k, 1 + ClkDiv);
            end
            checks++;
            if (done_k != Lat) begin errors++; $display("FAIL rd%0d_lat got=%0d want=%0d", v, done_k, Lat); end
            checks++;
            if (rdata !== vd[v]) begin errors++; $display("FAIL rd%0d_data got=%h want=%h", v, rdata, vd[v]); end
            checks++;
            if (cs_n !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL rd%0d_end cs=%b busy=%b want cs=1 busy=0", v, cs_n, busy);
            end
            checks++;
            if (cap_cmdaddr !== {RdCmd, vl[v]}) begin
                errors++; $display("FAIL rd%0d_mosi got=%h want=%h", v, cap_cmdaddr, {RdCmd, vl[v]});
            end
`ifdef SPI_FLASH_FAST_READ_EN
            checks++;
            if (cap_dummy !== 8'h00) begin errors++; $display("FAIL rd%0d_dummy got=%h want=00", v, cap_dummy); end
`endif
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd%0d_pulse got=%b want=0", v, done); end
            last_rdata = vd[v];
        end
    endtask

    task automatic test_back_to_back();
        int base = done_cnt;
        int done_k = -1;
        int fall_k = -1;
        int win;
        bit ok = 1'b0;
        @(negedge clk);
        strobe = 1'b1;
        addr   = 24'h200000;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done === 1'b1 && done_k < 0) done_k = k;
            if (done_k > 0 && k > done_k && cs_n === 1'b0 && fall_k < 0) fall_k = k;
        end
        strobe = 1'b0;
        #1 win = done_cnt - base;
        checks++; if (win != 1) begin errors++; $display("FAIL b2b_done_count got=%0d want=1", win); end
        checks++; if (done_k != Lat) begin errors++; $display("FAIL b2b_lat got=%0d want=%0d", done_k, Lat); end
        checks++;
        if (fall_k != Lat + 2) begin errors++; $display("FAIL b2b_next_cs got=%0d want=%0d", fall_k, Lat + 2); end
        for (int k = 0; k < 2 * Lat; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || rdata !== 32'h44332211) begin
            errors++; $display("FAIL b2b_second done=%b got=%h want=44332211", ok, rdata);
        end
        last_rdata = 32'h44332211;
    endtask

    task automatic test_strobe_before_init();
        bit cs_bad = 1'b0;
        bit ok;
        int base;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = done_cnt;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            strobe = (k >= 3 && k <= 10);
            addr   = 24'h200000;
            if (cs_n !== 1'b1) cs_bad = 1'b1;
        end
        strobe = 1'b0;
        checks++; if (cs_bad) begin errors++; $display("FAIL early_cs got=low want=high"); end
        wait_init(ok);
        checks++; if (!ok) begin errors++; $display("FAIL early_init got=timeout want=init"); end
        checks++;
        if (cs_low_last != 32) begin errors++; $display("FAIL early_wake_len got=%0d want=32", cs_low_last); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cs_n !== 1'b1) cs_bad = 1'b1;
        end
        #1;
        checks++; if (cs_bad) begin errors++; $display("FAIL early_idle_cs got=low want=high"); end
        checks++;
        if (done_cnt != base) begin errors++; $display("FAIL early_done got=%0d want=%0d", done_cnt - base, 0); end
        last_rdata = '0;
    endtask

    task automatic test_reset_mid_transfer();
        bit ok = 1'b0;
        int base;
        @(negedge clk);
        strobe = 1'b1;
        addr   = 24'h000107;
        @(posedge clk);
        #1 strobe = 1'b0;
        // Bit 30 spans t0+121..t0+124; SCK is high in its last two cycles.
        repeat (123) @(negedge clk);
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL mid_pre_sck got=%b want=1", sck); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs got=%b want=1", cs_n); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL mid_sck got=%b want=0", sck); end
        checks++;
        if (busy !== 1'b1 || init_done !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_flags busy=%b init=%b done=%b want 1 0 0", busy, init_done, done);
        end
        base = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_reinit got=timeout want=init"); end
        #1;
        checks++;
        if (done_cnt != base) begin errors++; $display("FAIL mid_no_done got=%0d want=0", done_cnt - base); end
        @(negedge clk);
        strobe = 1'b1;
        addr   = 24'h200003;
        @(posedge clk);
        #1 strobe = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < Lat + 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || rdata !== 32'h44332211) begin
            errors++; $display("FAIL mid_recover done=%b got=%h want=44332211", ok, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read();
        test_back_to_back();
        test_strobe_before_init();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
